// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM pipeline stage.
//   funct3_e : load/store size and sign encoding taken from funct3
//   state_e  : memory-access controller states
//   is_misaligned() : alignment rule for an access size and address low bits
package mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } funct3_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Address low bits that must be zero for each access size.
  localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      F3_H, F3_HU: return |(addr_lo & HALF_ALIGN_MASK);
      F3_W:        return |(addr_lo & WORD_ALIGN_MASK);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage and data memory.
//   req/we/addr/wdata/be : request side, driven by the MEM stage (master)
//   ack/rdata            : completion strobe and read word, driven by memory (slave)
interface mem_stage_if;
  import mem_pkg::*;

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata
  );

endinterface

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for the MEM stage.
//   st_funct3/st_addr_lo/st_data -> st_be/st_wdata : store enables and replicated data
//   ld_funct3/ld_addr_lo/ld_rdata -> ld_value      : extracted, sign/zero-extended load
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_value
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store data is replicated across all lanes so the enables alone pick the target.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    ld_byte = ld_rdata[7:0];
      2'd1:    ld_byte = ld_rdata[15:8];
      2'd2:    ld_byte = ld_rdata[23:16];
      default: ld_byte = ld_rdata[31:24];
    endcase
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    case (ld_funct3)
      F3_B:    ld_value = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_value = {24'b0, ld_byte};
      F3_H:    ld_value = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_value = {16'b0, ld_half};
      default: ld_value = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the data-memory bus, stalls the
// pipeline until the access completes, and registers the MEM/WB result.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ex_*                : EX/MEM pipeline entry (held stable while mem_stall)
//   mem_stall           : hold request to upstream stages
//   mem_forward_value   : EX-forwarding copy of ex_alu_result
//   dmem                : data-memory bus (master side)
//   wb_*                : registered MEM/WB outputs; wb_value doubles as WB forward value
//   wb_misaligned       : one-cycle flag for an aborted misaligned access
module mem_stage
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic [2:0]         ex_funct3,
  input  logic [31:0]        ex_alu_result,
  input  logic [31:0]        ex_store_data,
  input  logic               ex_reg_write,
  input  logic [4:0]         ex_rd,
  output logic               mem_stall,
  output logic [31:0]        mem_forward_value,
  mem_stage_if.master        dmem,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_value,
  output logic               wb_misaligned
);

  state_e      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  addr_lo_q;
  logic        reg_write_q;
  logic [4:0]  rd_q;

  logic        mem_op;
  logic        misaligned_op;
  logic        start_access;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_value;

  assign mem_forward_value = ex_alu_result;

  assign mem_op        = ex_valid && (ex_mem_read || ex_mem_write);
  assign misaligned_op = is_misaligned(ex_funct3, ex_alu_result[1:0]);
  assign start_access  = (state == ST_IDLE) && mem_op && !misaligned_op;

  // In BUSY the stall drops in the ack cycle so upstream advances on that edge.
  assign mem_stall = (state == ST_IDLE) ? start_access : !dmem.ack;

  assign dmem.req   = (state == ST_BUSY);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;

  load_store_align u_align (
    .st_funct3  (ex_funct3),
    .st_addr_lo (ex_alu_result[1:0]),
    .st_data    (ex_store_data),
    .st_be      (st_be),
    .st_wdata   (st_wdata),
    .ld_funct3  (funct3_q),
    .ld_addr_lo (addr_lo_q),
    .ld_rdata   (dmem.rdata),
    .ld_value   (ld_value)
  );

  // ---- EX/MEM -> MEM/WB boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      we_q          <= 1'b0;
      funct3_q      <= '0;
      addr_lo_q     <= '0;
      reg_write_q   <= 1'b0;
      rd_q          <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_value      <= '0;
      wb_misaligned <= 1'b0;
    end else begin
      // Every edge that does not retire an instruction writes a bubble.
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_misaligned <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid) begin
            if (!mem_op) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= ex_reg_write && (ex_rd != 5'd0);
              wb_rd        <= ex_rd;
              wb_value     <= ex_alu_result;
            end else if (misaligned_op) begin
              wb_valid      <= 1'b1;
              wb_rd         <= ex_rd;
              wb_value      <= ex_alu_result;
              wb_misaligned <= 1'b1;
            end else begin
              addr_q      <= {ex_alu_result[31:2], 2'b00};
              addr_lo_q   <= ex_alu_result[1:0];
              wdata_q     <= st_wdata;
              be_q        <= st_be;
              we_q        <= ex_mem_write;
              funct3_q    <= ex_funct3;
              reg_write_q <= ex_reg_write;
              rd_q        <= ex_rd;
              state       <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (dmem.ack) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= reg_write_q && !we_q && (rd_q != 5'd0);
            wb_rd        <= rd_q;
            wb_value     <= we_q ? 32'h0 : ld_value;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; data and address are fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 ex_valid  in  1  EX/MEM entry holds a live instruction.
REQ-005 ex_mem_read, ex_mem_write  in  1 each  load / store instruction.
REQ-006 ex_funct3  in  3  size/sign: 0 b, 1 h, 2 w, 4 bu, 5 hu.
REQ-007 ex_alu_result  in  32  effective address, or ALU result for non-memory ops.
REQ-008 ex_store_data  in  32  forwarded rs2 value (store data).
REQ-009 ex_reg_write  in  1, ex_rd  in  5  destination write-back control.
REQ-010 mem_stall  out  1  upstream SHALL hold all ex_* inputs stable while high.
REQ-011 mem_forward_value  out  32  combinational copy of ex_alu_result, for EX forwarding.
REQ-012 dmem_req, dmem_we  out  1 each; dmem_addr  out  32 (word-aligned); dmem_wdata  out  32; dmem_be  out  4.
REQ-013 dmem_ack  in  1, dmem_rdata  in  32  completion strobe and read word.
REQ-014 wb_valid, wb_reg_write  out  1; wb_rd  out  5; wb_value  out  32  registered MEM/WB outputs (wb_value doubles as wb_forward_value).
REQ-015 wb_misaligned  out  1  registered one-cycle flag for an aborted misaligned access.

Function
REQ-016 FSM states: IDLE and BUSY.
REQ-017 Non-memory op (ex_valid, no read/write): mem_stall=0; wb_* update at the next edge with value=ex_alu_result; latency 1 cycle.
REQ-018 Aligned memory op in IDLE: mem_stall=1 combinationally; address, data, be, we and wb control latch at the edge; next state BUSY.
REQ-019 BUSY: dmem_req=1, with addr/we/wdata/be held constant from the latch until the dmem_ack cycle.
REQ-020 BUSY with dmem_ack=1: mem_stall=0; wb_* load at that edge; next state IDLE; minimum memory-op latency is 2 cycles.
REQ-021 BUSY with dmem_ack=0: mem_stall=1; state unchanged; no timeout.
REQ-022 Each stalled edge SHALL write a bubble into WB (wb_valid=0, wb_reg_write=0).
REQ-023 Alignment: h/hu require addr[0]=0; w requires addr[1:0]=0.
REQ-024 Misaligned access: no dmem_req; no stall; next edge gives wb_valid=1, wb_reg_write=0, wb_misaligned=1.
REQ-025 dmem_addr = {addr[31:2],2'b00}.
REQ-026 Store byte enables: sb be=1<<addr[1:0] with data byte replicated x4; sh be=0011/1100 by addr[1] with halfword replicated x2; sw be=1111.
REQ-027 Loads: select the byte or halfword from dmem_rdata by addr[1:0]; b/h sign-extend; bu/hu zero-extend; w passes through.
REQ-028 Stores SHALL produce wb_reg_write=0.
REQ-029 wb_reg_write SHALL be forced to 0 whenever wb_rd=0.
REQ-030 dmem_ack received in IDLE SHALL be ignored.
REQ-031 ex_valid=0 in IDLE: no stall; WB gets a bubble.

Reset
REQ-032 rst_n low: state=IDLE; dmem_req=0; all wb_* outputs and wb_misaligned=0; wb_value=0; latched bus fields=0.
REQ-033 Reset mid-BUSY abandons the access; no write-back occurs; a stale ack after release SHALL be ignored.

Structure
REQ-034 Package mem_pkg: funct3 size enum, state enum, alignment helper constants.
REQ-035 Sub-module load_store_align: combinational; generates be/wdata and extracts/extends load data.

Verification
REQ-036 ALU op, alu_result=0x1234, rd=5 -> next edge wb_valid=1, wb_rd=5, wb_value=0x1234; mem_stall never high.
REQ-037 lb addr=0x103, rdata=0x80FF_FF00, ack after 3 BUSY cycles -> dmem_addr=0x100, mem_stall high 4 cycles, wb_value=0xFFFF_FF80.
REQ-038 sh addr=0x202, data=0xABCD -> dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, wb_reg_write=0.
REQ-039 lw addr=0x101 -> no dmem_req, wb_misaligned=1 for one cycle, wb_reg_write=0.
REQ-040 rst_n low during BUSY, then ack pulse after release -> dmem_req=0, state IDLE, no wb_valid.
REQ-041 lhu addr=0x2, rdata=0x8001_0000, rd=0 -> wb_value=0x0000_8001, wb_reg_write=0.
